// File: rtl/shift_reg_n.sv
// rtl/shift_reg_n.sv - WIDTH-bit load/shift/rotate register with autonomous burst shifter
// Busy/Done are pure decodes of the registered FSM state.
module shift_reg_n #(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic             Shift_En,
  input  logic             Dir,
  input  logic             Rotate,
  input  logic             Shift_In,
  input  logic             Start,
  input  logic [CNT_W-1:0] Count,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Shift_Out,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic             dir_q;
  logic             rot_q;
  logic [CNT_W-1:0] count_clamped;
  logic             eff_dir;

  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v,
                                                  input logic left,
                                                  input logic rot,
                                                  input logic sin);
    logic fill;
    if (left) begin
      fill = rot ? v[WIDTH-1] : sin;
      return {v[WIDTH-2:0], fill};
    end else begin
      fill = rot ? v[0] : sin;
      return {fill, v[WIDTH-1:1]};
    end
  endfunction

  assign count_clamped = (Count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : Count;

  // During a burst the latched direction decides which end ejects next.
  assign eff_dir   = (state == BUSY) ? dir_q : Dir;
  assign Shift_Out = eff_dir ? Data_Out[WIDTH-1] : Data_Out[0];
  assign Busy      = (state == BUSY);
  assign Done      = (state == DONE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Data_Out  <= '0;
      state     <= IDLE;
      remaining <= '0;
      dir_q     <= 1'b0;
      rot_q     <= 1'b0;
    end else if (Load) begin
      // Load wins everywhere and silently aborts any burst.
      Data_Out <= D;
      state    <= IDLE;
    end else begin
      case (state)
        BUSY: begin
          Data_Out  <= shift_once(Data_Out, dir_q, rot_q, Shift_In);
          remaining <= remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) state <= DONE;
        end
        IDLE: begin
          if (Start) begin
            if (count_clamped == '0) begin
              state <= DONE;
            end else begin
              dir_q     <= Dir;
              rot_q     <= Rotate;
              remaining <= count_clamped;
              state     <= BUSY;
            end
          end else if (Shift_En) begin
            Data_Out <= shift_once(Data_Out, Dir, Rotate, Shift_In);
          end
        end
        DONE: begin
          state <= IDLE;
          if (Shift_En) Data_Out <= shift_once(Data_Out, Dir, Rotate, Shift_In);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_reg_n.sv
// tb/tb_shift_reg_n.sv - scoreboard bench for shift_reg_n at WIDTH=8
module tb_shift_reg_n;
  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             Clk = 1'b0;
  logic             Reset, Load, Shift_En, Dir, Rotate, Shift_In, Start;
  logic [WIDTH-1:0] D;
  logic [CNT_W-1:0] Count;
  logic [WIDTH-1:0] Data_Out;
  logic             Shift_Out, Busy, Done;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             busy;
    logic             done;
    string            tag;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             e;
  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] mdl;

  shift_reg_n #(.WIDTH(WIDTH)) dut (
    .Clk(Clk), .Reset(Reset), .Load(Load), .D(D), .Shift_En(Shift_En),
    .Dir(Dir), .Rotate(Rotate), .Shift_In(Shift_In), .Start(Start), .Count(Count),
    .Data_Out(Data_Out), .Shift_Out(Shift_Out), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] v, input logic left,
                                                 input logic rot, input logic sin);
    logic [2*WIDTH-1:0] dbl;
    dbl = {v, v};
    if (rot) return left ? dbl[2*WIDTH-2 -: WIDTH] : dbl[WIDTH -: WIDTH];
    return left ? ((v << 1) | WIDTH'(sin)) : ((v >> 1) | (WIDTH'(sin) << (WIDTH - 1)));
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Load = 1'b0; Shift_En = 1'b0; Start = 1'b0;
    D = '0; Dir = 1'b0; Rotate = 1'b0; Shift_In = 1'b0; Count = '0;
    step(); step();
    Reset = 1'b0;
    checks++; if (Data_Out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", Data_Out); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", Done); end
    Load = 1'b1; D = 8'hFF; step(); Load = 1'b0;
    Start = 1'b1; Count = 4'd8; step(); Start = 1'b0;
    step();
    Reset = 1'b1; #1;
    checks++; if (Data_Out !== 8'h00) begin errors++; $display("FAIL async_reset_data: got %h want 00", Data_Out); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL async_reset_done: got %b want 0", Done); end
    step(); Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back('{8'h00, 1'b0, 1'b0, "post_reset"});
      step();
      e = exp_q.pop_front();
      checks++; if (Data_Out !== e.data) begin errors++; $display("FAIL %s data: got %h want %h", e.tag, Data_Out, e.data); end
      checks++; if (Busy !== e.busy) begin errors++; $display("FAIL %s busy: got %b want %b", e.tag, Busy, e.busy); end
      checks++; if (Done !== e.done) begin errors++; $display("FAIL %s done: got %b want %b", e.tag, Done, e.done); end
    end
    Load = 1'b1; D = 8'hA5;
    exp_q.push_back('{8'hA5, 1'b0, 1'b0, "load_a5"});
    step(); Load = 1'b0;
    e = exp_q.pop_front();
    checks++; if (Data_Out !== e.data) begin errors++; $display("FAIL %s data: got %h want %h", e.tag, Data_Out, e.data); end
  endtask

  task automatic test_single_step();
    Load = 1'b1; D = 8'h81; step(); Load = 1'b0;
    Shift_En = 1'b1; Dir = 1'b0; Rotate = 1'b0; Shift_In = 1'b0; #1;
    checks++; if (Shift_Out !== 1'b1) begin errors++; $display("FAIL shr_shift_out: got %b want 1", Shift_Out); end
    exp_q.push_back('{8'h40, 1'b0, 1'b0, "shr_fill0"});
    step(); Shift_En = 1'b0;
    e = exp_q.pop_front();
    checks++; if (Data_Out !== e.data) begin errors++; $display("FAIL %s data: got %h want %h", e.tag, Data_Out, e.data); end
    Load = 1'b1; D = 8'h81; step(); Load = 1'b0;
    Shift_En = 1'b1; Dir = 1'b1; Rotate = 1'b1; #1;
    checks++; if (Shift_Out !== 1'b1) begin errors++; $display("FAIL rol_shift_out: got %b want 1", Shift_Out); end
    exp_q.push_back('{8'h03, 1'b0, 1'b0, "rol"});
    step();
    e = exp_q.pop_front();
    checks++; if (Data_Out !== e.data) begin errors++; $display("FAIL %s data: got %h want %h", e.tag, Data_Out, e.data); end
    mdl = 8'h03;
    for (int i = 0; i < 16; i++) begin
      Dir = 1'($urandom_range(1)); Rotate = 1'($urandom_range(1)); Shift_In = 1'($urandom_range(1)); #1;
      checks++; if (Shift_Out !== (Dir ? mdl[WIDTH-1] : mdl[0])) begin errors++; $display("FAIL rand_shift_out: got %b want %b", Shift_Out, Dir ? mdl[WIDTH-1] : mdl[0]); end
      mdl = ref_shift(mdl, Dir, Rotate, Shift_In);
      exp_q.push_back('{mdl, 1'b0, 1'b0, "rand_step"});
      step();
      e = exp_q.pop_front();
      checks++; if (Data_Out !== e.data) begin errors++; $display("FAIL %s data: got %h want %h", e.tag, Data_Out, e.data); end
    end
    Shift_En = 1'b0;
  endtask

  task automatic test_burst();
    Load = 1'b1; D = 8'h96; step(); Load = 1'b0;
    Start = 1'b1; Count = 4'd4; Dir = 1'b0; Rotate = 1'b1; Shift_In = 1'b0;
    exp_q.push_back('{8'h96, 1'b1, 1'b0, "burst_start"});
    step();
    Count = 4'd3;
    mdl = 8'h96;
    e = exp_q.pop_front();
    checks++; if (Data_Out !== e.data) begin errors++; $display("FAIL %s data: got %h want %h", e.tag, Data_Out, e.data); end
    checks++; if (Busy !== e.busy) begin errors++; $display("FAIL %s busy: got %b want %b", e.tag, Busy, e.busy); end
    for (int i = 1; i <= 4; i++) begin
      Dir = ~Dir;
      mdl = ref_shift(mdl, 1'b0, 1'b1, Shift_In);
      exp_q.push_back('{mdl, i < 4, i == 4, "burst_shift"});
      step();
      e = exp_q.pop_front();
      checks++; if (Data_Out !== e.data) begin errors++; $display("FAIL %s data: got %h want %h", e.tag, Data_Out, e.data); end
      checks++; if (Busy !== e.busy) begin errors++; $display("FAIL %s busy: got %b want %b", e.tag, Busy, e.busy); end
      checks++; if (Done !== e.done) begin errors++; $display("FAIL %s done: got %b want %b", e.tag, Done, e.done); end
    end
    checks++; if (Data_Out !== 8'h69) begin errors++; $display("FAIL burst_final: got %h want 69", Data_Out); end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{8'h69, 1'b0, 1'b0, "burst_after"});
      step();
      Start = 1'b0;
      e = exp_q.pop_front();
      checks++; if (Data_Out !== e.data) begin errors++; $display("FAIL %s data: got %h want %h", e.tag, Data_Out, e.data); end
      checks++; if (Busy !== e.busy) begin errors++; $display("FAIL %s busy: got %b want %b", e.tag, Busy, e.busy); end
      checks++; if (Done !== e.done) begin errors++; $display("FAIL %s done: got %b want %b", e.tag, Done, e.done); end
    end
  endtask

  task automatic test_serial_fill();
    logic [WIDTH-1:0] orig;
    logic [7:0]       bits;
    orig = 8'h5A; bits = 8'b1011_0010;
    Load = 1'b1; D = orig; step(); Load = 1'b0;
    Start = 1'b1; Count = 4'd8; Dir = 1'b1; Rotate = 1'b0;
    step();
    Start = 1'b0; Dir = 1'b0; Rotate = 1'b1;
    mdl = orig;
    for (int i = 0; i < 8; i++) begin
      Shift_In = bits[7-i]; #1;
      checks++; if (Shift_Out !== orig[7-i]) begin errors++; $display("FAIL fill_shift_out[%0d]: got %b want %b", i, Shift_Out, orig[7-i]); end
      mdl = ref_shift(mdl, 1'b1, 1'b0, Shift_In);
      exp_q.push_back('{mdl, i < 7, i == 7, "fill_shift"});
      step();
      e = exp_q.pop_front();
      checks++; if (Data_Out !== e.data) begin errors++; $display("FAIL %s data: got %h want %h", e.tag, Data_Out, e.data); end
      checks++; if (Busy !== e.busy) begin errors++; $display("FAIL %s busy: got %b want %b", e.tag, Busy, e.busy); end
      checks++; if (Done !== e.done) begin errors++; $display("FAIL %s done: got %b want %b", e.tag, Done, e.done); end
    end
    checks++; if (Data_Out !== 8'hB2) begin errors++; $display("FAIL fill_final: got %h want b2", Data_Out); end
    step();
  endtask

  task automatic test_edges();
    int busy_cycles, done_cycles;
    Load = 1'b1; D = 8'h3C; step(); Load = 1'b0;
    Start = 1'b1; Count = 4'd0;
    exp_q.push_back('{8'h3C, 1'b0, 1'b1, "count0"});
    step(); Start = 1'b0;
    e = exp_q.pop_front();
    checks++; if (Data_Out !== e.data) begin errors++; $display("FAIL %s data: got %h want %h", e.tag, Data_Out, e.data); end
    checks++; if (Busy !== e.busy) begin errors++; $display("FAIL %s busy: got %b want %b", e.tag, Busy, e.busy); end
    checks++; if (Done !== e.done) begin errors++; $display("FAIL %s done: got %b want %b", e.tag, Done, e.done); end
    Shift_En = 1'b1; Dir = 1'b0; Rotate = 1'b0; Shift_In = 1'b1;
    exp_q.push_back('{8'h9E, 1'b0, 1'b0, "shift_in_done"});
    step(); Shift_En = 1'b0;
    e = exp_q.pop_front();
    checks++; if (Data_Out !== e.data) begin errors++; $display("FAIL %s data: got %h want %h", e.tag, Data_Out, e.data); end
    checks++; if (Done !== e.done) begin errors++; $display("FAIL %s done: got %b want %b", e.tag, Done, e.done); end
    Load = 1'b1; D = 8'h01; step(); Load = 1'b0;
    Start = 1'b1; Count = 4'd15; Dir = 1'b0; Rotate = 1'b1;
    busy_cycles = 0; done_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      step(); Start = 1'b0;
      if (Busy) busy_cycles++;
      if (Done) begin
        done_cycles++;
        checks++; if (Data_Out !== 8'h01) begin errors++; $display("FAIL clamp_data: got %h want 01", Data_Out); end
      end
    end
    checks++; if (busy_cycles !== 8) begin errors++; $display("FAIL clamp_busy_cycles: got %0d want 8", busy_cycles); end
    checks++; if (done_cycles !== 1) begin errors++; $display("FAIL clamp_done_pulses: got %0d want 1", done_cycles); end
  endtask

  task automatic test_abort();
    Load = 1'b1; D = 8'hFF; step(); Load = 1'b0;
    Start = 1'b1; Count = 4'd8; Dir = 1'b0; Rotate = 1'b0; Shift_In = 1'b0;
    exp_q.push_back('{8'hFF, 1'b1, 1'b0, "abort_start"});
    exp_q.push_back('{8'h7F, 1'b1, 1'b0, "abort_shift1"});
    exp_q.push_back('{8'h3C, 1'b0, 1'b0, "abort_load"});
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin Load = 1'b1; D = 8'h3C; end
      step();
      Start = 1'b0; Load = 1'b0;
      e = exp_q.pop_front();
      checks++; if (Data_Out !== e.data) begin errors++; $display("FAIL %s data: got %h want %h", e.tag, Data_Out, e.data); end
      checks++; if (Busy !== e.busy) begin errors++; $display("FAIL %s busy: got %b want %b", e.tag, Busy, e.busy); end
      checks++; if (Done !== e.done) begin errors++; $display("FAIL %s done: got %b want %b", e.tag, Done, e.done); end
    end
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back('{8'h3C, 1'b0, 1'b0, "post_abort"});
      step();
      e = exp_q.pop_front();
      checks++; if (Data_Out !== e.data) begin errors++; $display("FAIL %s data: got %h want %h", e.tag, Data_Out, e.data); end
      checks++; if (Done !== e.done) begin errors++; $display("FAIL %s done: got %b want %b", e.tag, Done, e.done); end
    end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_burst();
    test_serial_fill();
    test_edges();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
